// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM driving datapath enables and mux
// selects, with a req/ready memory handshake, an illegal-instruction trap and a retire counter.
module mips_mc_ctrl #(
  parameter int OPCODE_WIDTH   = 6,
  parameter int FUNCT_WIDTH    = 6,
  parameter int ALU_CTRL_WIDTH = 3,
  parameter int MEM_WAIT_EN    = 1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [OPCODE_WIDTH-1:0]   opcode,
  input  logic [FUNCT_WIDTH-1:0]    funct,
  input  logic                      alu_zero,
  input  logic                      mem_ready,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      iord,
  output logic                      ir_en,
  output logic                      pc_en,
  output logic [1:0]                pc_src,
  output logic                      alu_src_a,
  output logic [1:0]                alu_src_b,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl,
  output logic                      reg_dst,
  output logic                      mem_to_reg,
  output logic                      rf_we,
  output logic                      illegal_instr,
  output logic [CNT_WIDTH-1:0]      instr_count,
  output logic [3:0]                state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(6'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_J     = OPCODE_WIDTH'(6'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ   = OPCODE_WIDTH'(6'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI  = OPCODE_WIDTH'(6'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_LW    = OPCODE_WIDTH'(6'h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_SW    = OPCODE_WIDTH'(6'h2B);

  localparam logic [FUNCT_WIDTH-1:0] FN_ADD = FUNCT_WIDTH'(6'h20);
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB = FUNCT_WIDTH'(6'h22);
  localparam logic [FUNCT_WIDTH-1:0] FN_AND = FUNCT_WIDTH'(6'h24);
  localparam logic [FUNCT_WIDTH-1:0] FN_OR  = FUNCT_WIDTH'(6'h25);
  localparam logic [FUNCT_WIDTH-1:0] FN_SLT = FUNCT_WIDTH'(6'h2A);

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND = ALU_CTRL_WIDTH'(3'b000);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR  = ALU_CTRL_WIDTH'(3'b001);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD = ALU_CTRL_WIDTH'(3'b010);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB = ALU_CTRL_WIDTH'(3'b110);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT = ALU_CTRL_WIDTH'(3'b111);

  state_t                    state;
  state_t                    next_state;
  logic                      rdy;
  logic                      retire;
  logic                      legal_funct;
  logic [ALU_CTRL_WIDTH-1:0] funct_alu;

  // With waits disabled every memory access completes in its first cycle.
  assign rdy     = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign state_o = state;

  always_comb begin
    legal_funct = 1'b1;
    funct_alu   = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: legal_funct = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      illegal_instr <= 1'b0;
      instr_count   <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + 1'b1;
      if (next_state == S_TRAP) illegal_instr <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctrl   = '0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    rf_we      = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = ALU_ADD;
        ir_en     = rdy;
        pc_en     = rdy;
        if (rdy) next_state = S_DECODE;
      end
      S_DECODE: begin
        // ALU forms PC + (imm<<2) here so BRANCH can take it from ALU_result.
        alu_src_b = 2'b11;
        alu_ctrl  = ALU_ADD;
        if (opcode == OP_LW || opcode == OP_SW)       next_state = S_MEMADR;
        else if (opcode == OP_RTYPE && legal_funct)   next_state = S_EXECUTE;
        else if (opcode == OP_BEQ)                    next_state = S_BRANCH;
        else if (opcode == OP_ADDI)                   next_state = S_ADDIEXEC;
        else if (opcode == OP_J)                      next_state = S_JUMP;
        else                                          next_state = S_TRAP;
      end
      S_MEMADR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        next_state = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (rdy) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        mem_to_reg = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (rdy) begin
          next_state = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = funct_alu;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we      = 1'b1;
        reg_dst    = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = ALU_SUB;
        pc_src     = 2'b01;
        pc_en      = alu_zero;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        next_state = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_we      = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
Parametrised multi-cycle control unit for the non-pipelined MIPS datapath. It drives the enables and mux selects for the PC, instruction, A/B/data/ALU registers and the register file. Memory accesses use a req/ready handshake with wait states, so the core can sit on a slow or shared memory. The block also traps illegal opcode/funct combinations and counts retired instructions.

Parameters:
OPCODE_WIDTH, 6, opcode field width
FUNCT_WIDTH, 6, funct field width
ALU_CTRL_WIDTH, 3, ALU control code width
MEM_WAIT_EN, 1, 1 = honour mem_ready; 0 = treat mem_ready as constant 1
CNT_WIDTH, 32, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
opcode  in  OPCODE_WIDTH  instruction[31:26] from the instruction register
funct  in  FUNCT_WIDTH  instruction[5:0]
alu_zero  in  1  ALU zero flag (combinational)
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
mem_we  out  1  memory write
iord  out  1  0 = address from PC, 1 = address from ALU_result
ir_en  out  1  instruction register load
pc_en  out  1  PC load
pc_src  out  2  00 = ALU out, 01 = ALU_result reg, 10 = jump target
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
alu_ctrl  out  ALU_CTRL_WIDTH  000 and, 001 or, 010 add, 110 sub, 111 slt
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALU_result, 1 = data reg
rf_we  out  1  register file write
illegal_instr  out  1  sticky trap flag
instr_count  out  CNT_WIDTH  retired instruction count
state_o  out  4  current state encoding, for debug

Behaviour:
- Moore FSM. All outputs decode combinationally from state, except the pc_en/ir_en gating by mem_ready and alu_zero described below. Any output not named for a state is 0.
- Reset (rst=1 at a clk edge): state=FETCH, illegal_instr=0, instr_count=0. Reset mid-instruction abandons the instruction with no count. Combinational outputs follow FETCH on the next cycle.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11, TRAP 12.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00. ir_en=pc_en=mem_ready. Go to DECODE when mem_ready, else stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_ctrl=add (precomputes the branch target). Next state by opcode:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 with legal funct -> EXECUTE
  - 0x04 -> BRANCH
  - 0x08 -> ADDIEXEC
  - 0x02 -> JUMP
  - anything else -> TRAP
  - Legal funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Go to MEMREAD for 0x23, MEMWRITE for 0x2B.
- MEMREAD: mem_req=1, iord=1. Stay until mem_ready, then go to MEMWB.
- MEMWB: rf_we=1, reg_dst=0, mem_to_reg=1. Retire.
- MEMWRITE: mem_req=1, mem_we=1, iord=1. Stay until mem_ready, then retire.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Go to ALUWB.
- ALUWB: rf_we=1, reg_dst=1, mem_to_reg=0. Retire.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01, pc_en=alu_zero. Retire.
- ADDIEXEC: alu_src_a=1, alu_src_b=10, add. Go to ADDIWB.
- ADDIWB: rf_we=1, reg_dst=0, mem_to_reg=0. Retire.
- JUMP: pc_src=10, pc_en=1. Retire.
- Retire means: next state = FETCH and instr_count increments by 1 on that edge.
  - instr_count wraps modulo 2^CNT_WIDTH.
  - A memory state that is still waiting is not a retire.
- TRAP: illegal_instr set to 1 on entry and held. The FSM stays in TRAP with all enables 0 until rst. No count.
- Cycle counts with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- MEM_WAIT_EN=0: mem_ready is ignored and every memory state takes exactly 1 cycle.
- mem_req stays high and address selects stay stable while waiting.
- mem_ready outside a memory state is ignored.

Test Plan:
- lw (opcode 0x23), mem_ready low for 2 cycles in FETCH and 1 in MEMREAD -> 8 cycles total; ir_en and pc_en pulse exactly once; rf_we=1 with mem_to_reg=1 in MEMWB; instr_count 0->1.
- R-type add then sub (funct 0x20, 0x22), mem_ready tied 1 -> 4 cycles each; alu_ctrl 010 then 110 in EXECUTE; rf_we with reg_dst=1 in ALUWB; instr_count=2.
- beq twice, alu_zero=1 then 0 -> 3 cycles each; pc_en=1 with pc_src=01 in the first BRANCH, pc_en=0 in the second; rf_we never asserted.
- Opcode 0x3F, then a legal instruction presented -> TRAP after DECODE; illegal_instr=1 held; no enables; instr_count unchanged; rst clears illegal_instr and returns state_o to 0.
- rst asserted in MEMREAD with mem_req=1 -> next cycle state_o=0, mem_req=1, iord=0, instr_count=0.
- MEM_WAIT_EN=0, mem_ready held 0, sequence sw, addi, j -> 4+4+3=11 cycles; instr_count=3; mem_we=1 only in MEMWRITE.
